// File: rtl/barrel_right_pipe.sv
// Pipelined right barrel shifter (logical / arithmetic / rotate), one log-stage per amount bit.
// Latency: SHW register stages, one op per cycle. Backpressure: per-stage enables, bubbles collapse, ready_o = en of stage 0.
// Output holds stable while valid_o && !ready_i.
module barrel_right_pipe #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] i_a,
    input  logic [SHW-1:0]   num_right_i,
    input  logic [1:0]       mode_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [WIDTH-1:0] o_y,
    output logic             valid_o,
    input  logic             ready_i
);
    localparam logic [1:0] MODE_ARITH = 2'b01;
    localparam logic [1:0] MODE_ROT   = 2'b10;

    logic [WIDTH-1:0] data_q [SHW];
    logic [SHW-1:0]   amt_q  [SHW];
    logic [1:0]       mode_q [SHW];
    logic [SHW-1:0]   sign_q;
    logic [SHW-1:0]   vld_q;
    logic [SHW-1:0]   en;
    logic             unused_tail;

    // Fill source: sign bits for arithmetic, the operand itself for rotate, zeros otherwise (incl. reserved mode).
    function automatic logic [WIDTH-1:0] shift_step(
        input logic [WIDTH-1:0] d,
        input logic             do_shift,
        input int unsigned      n,
        input logic [1:0]       m,
        input logic             s
    );
        logic [WIDTH-1:0] fill;
        case (m)
            MODE_ARITH: fill = {WIDTH{s}};
            MODE_ROT:   fill = d;
            default:    fill = '0;
        endcase
        return do_shift ? ((d >> n) | (fill << (WIDTH - n))) : d;
    endfunction

    // en[k] = !v[k] || en[k+1], unrolled from the output side.
    always_comb begin
        logic acc;
        en  = '0;
        acc = ready_i;
        for (int k = SHW - 1; k >= 0; k--) begin
            acc   = acc | ~vld_q[k];
            en[k] = acc;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < SHW; k++) begin
                data_q[k] <= '0;
                amt_q[k]  <= '0;
                mode_q[k] <= '0;
            end
            sign_q <= '0;
            vld_q  <= '0;
        end else begin
            if (en[0]) begin
                vld_q[0]  <= valid_i;
                data_q[0] <= shift_step(i_a, num_right_i[0], 1, mode_i, i_a[WIDTH-1]);
                amt_q[0]  <= num_right_i >> 1;
                mode_q[0] <= mode_i;
                sign_q[0] <= i_a[WIDTH-1];
            end
            // amt_q holds only the not-yet-applied bits, so bit 0 is always the next step.
            for (int k = 1; k < SHW; k++) begin
                if (en[k]) begin
                    vld_q[k]  <= vld_q[k-1];
                    data_q[k] <= shift_step(data_q[k-1], amt_q[k-1][0], 1 << k,
                                            mode_q[k-1], sign_q[k-1]);
                    amt_q[k]  <= amt_q[k-1] >> 1;
                    mode_q[k] <= mode_q[k-1];
                    sign_q[k] <= sign_q[k-1];
                end
            end
        end
    end

    assign ready_o     = en[0];
    assign valid_o     = vld_q[SHW-1];
    assign o_y         = data_q[SHW-1];
    assign unused_tail = ^{amt_q[SHW-1], mode_q[SHW-1], sign_q[SHW-1]};

endmodule

// File: tb/tb_barrel_right_pipe.sv
// Scoreboard bench for barrel_right_pipe: directed vectors in, expected results queued, monitor compares.
module tb_barrel_right_pipe;
    localparam int WIDTH = 32;
    localparam int SHW   = 5;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [WIDTH-1:0] i_a;
    logic [SHW-1:0]   num_right_i;
    logic [1:0]       mode_i;
    logic             valid_i;
    logic             ready_o;
    logic [WIDTH-1:0] o_y;
    logic             valid_o;
    logic             ready_i;

    barrel_right_pipe #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .i_a(i_a), .num_right_i(num_right_i),
        .mode_i(mode_i), .valid_i(valid_i), .ready_o(ready_o), .o_y(o_y),
        .valid_o(valid_o), .ready_i(ready_i)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] a;
        logic [4:0]  n;
        logic [1:0]  m;
        logic [31:0] y;
    } vec_t;

    typedef struct {
        logic [31:0] y;
        int          edge_n;
        bit          chk_lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
        end
    endfunction

    function automatic void check1(input string name, input logic act, input logic req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Monitor: sampled mid-low-phase, after the driver has set this cycle's inputs.
    always @(negedge clk_i) begin
        #1;
        if (!rst_i && valid_o) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got 0x%08h, expected no output", o_y);
            end else begin
                check("o_y", o_y, exp_q[0].y);
                if (ready_i) begin
                    if (exp_q[0].chk_lat)
                        check("latency", 32'(cyc - exp_q[0].edge_n), 32'(SHW - 1));
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic drive(input vec_t v);
        i_a         = v.a;
        num_right_i = v.n;
        mode_i      = v.m;
        valid_i     = 1'b1;
    endtask

    task automatic send(input vec_t v, input bit lat, input bit must_rdy);
        int w = 0;
        @(negedge clk_i);
        drive(v);
        #1;
        if (must_rdy) check1("ready_o_at_issue", ready_o, 1'b1);
        while (!ready_o && w < 100) begin
            @(negedge clk_i);
            #1;
            w++;
        end
        if (!ready_o) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got ready_o=0 for %0d cycles, expected acceptance", w);
        end else begin
            exp_q.push_back('{y: v.y, edge_n: cyc + 1, chk_lat: lat});
        end
    endtask

    task automatic idle();
        @(negedge clk_i);
        valid_i = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 200) begin
            @(negedge clk_i);
            #2;
            w++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d entries pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    vec_t t_b2b [6];
    vec_t t_stall [7];
    vec_t v_first, v_bubble, v_fresh;

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, expected $finish");
        $fatal(1);
    end

    initial begin
        int accepted;

        v_first  = '{32'hF0F0F0F0, 5'd1,  2'b00, 32'h78787878};
        v_bubble = '{32'hA5A5A5A5, 5'd2,  2'b10, 32'h69696969};
        v_fresh  = '{32'hDEADBEEF, 5'd12, 2'b01, 32'hFFFDEADB};
        t_b2b[0] = '{32'hF0F0F0F0, 5'd4,  2'b01, 32'hFF0F0F0F};
        t_b2b[1] = '{32'hF0F0F0F0, 5'd4,  2'b10, 32'h0F0F0F0F};
        t_b2b[2] = '{32'h80000000, 5'd31, 2'b00, 32'h00000001};
        t_b2b[3] = '{32'h12345678, 5'd8,  2'b10, 32'h78123456};
        t_b2b[4] = '{32'h12345678, 5'd0,  2'b11, 32'h12345678};
        t_b2b[5] = '{32'h80000000, 5'd31, 2'b01, 32'hFFFFFFFF};
        t_stall[0] = '{32'h12345678, 5'd4,  2'b00, 32'h01234567};
        t_stall[1] = '{32'h12345678, 5'd4,  2'b10, 32'h81234567};
        t_stall[2] = '{32'h87654321, 5'd4,  2'b01, 32'hF8765432};
        t_stall[3] = '{32'h87654321, 5'd16, 2'b00, 32'h00008765};
        t_stall[4] = '{32'h87654321, 5'd16, 2'b10, 32'h43218765};
        t_stall[5] = '{32'hFFFF0000, 5'd8,  2'b01, 32'hFFFFFF00};
        t_stall[6] = '{32'h0000FFFF, 5'd3,  2'b11, 32'h00001FFF};

        rst_i       = 1'b1;
        valid_i     = 1'b0;
        ready_i     = 1'b1;
        i_a         = '0;
        num_right_i = '0;
        mode_i      = '0;
        #1;
        check1("reset_valid_o", valid_o, 1'b0);
        check("reset_o_y", o_y, 32'h0);
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check1("post_reset_ready_o", ready_o, 1'b1);
        check1("post_reset_valid_o", valid_o, 1'b0);

        // Single beat, valid_o must pulse for exactly one cycle.
        send(v_first, 1'b1, 1'b1);
        idle();
        drain();
        @(negedge clk_i);
        #2;
        check1("single_beat_valid_drop", valid_o, 1'b0);

        // Back-to-back beats, ready_o must never drop.
        foreach (t_b2b[i]) send(t_b2b[i], 1'b1, 1'b1);
        idle();
        drain();

        // Bubble collapse: one beat held at the output, ready_o stays high.
        @(negedge clk_i);
        ready_i = 1'b0;
        send(v_bubble, 1'b0, 1'b1);
        idle();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_i);
            #2;
            check1("bubble_ready_o", ready_o, 1'b1);
        end
        check1("bubble_valid_o_held", valid_o, 1'b1);
        @(negedge clk_i);
        ready_i = 1'b1;
        drain();

        // Stall: fill all stages, then release and verify ordered drain.
        @(negedge clk_i);
        ready_i  = 1'b0;
        accepted = 0;
        while (accepted < 7) begin
            @(negedge clk_i);
            drive(t_stall[accepted]);
            #1;
            if (!ready_o) break;
            exp_q.push_back('{y: t_stall[accepted].y, edge_n: cyc + 1, chk_lat: 1'b0});
            accepted++;
        end
        check("stall_accept_count", 32'(accepted), 32'd5);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            #1;
            check1("stall_ready_o_low", ready_o, 1'b0);
        end
        @(negedge clk_i);
        ready_i = 1'b1;
        #1;
        check1("release_ready_o_same_cycle", ready_o, 1'b1);
        if (ready_o)
            exp_q.push_back('{y: t_stall[5].y, edge_n: cyc + 1, chk_lat: 1'b0});
        send(t_stall[6], 1'b0, 1'b1);
        idle();
        drain();

        // Asynchronous reset while three beats are in flight.
        for (int i = 0; i < 3; i++) send(t_b2b[i], 1'b1, 1'b1);
        idle();
        @(posedge clk_i);
        @(posedge clk_i);
        #2;
        check1("pre_reset_valid_o", valid_o, 1'b1);
        rst_i = 1'b1;
        exp_q.delete();
        #1;
        check1("async_reset_valid_o", valid_o, 1'b0);
        check("async_reset_o_y", o_y, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (8) @(negedge clk_i);
        send(v_fresh, 1'b1, 1'b1);
        idle();
        drain();
        repeat (3) @(negedge clk_i);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/barrel_right_pipe.md
Name: barrel_right_pipe

Overview:
Pipelined 32-bit right barrel shifter. It supports logical, arithmetic and rotate modes with a valid/ready handshake on input and output. It is the right-shift counterpart of the registered left barrel shifter and sits in the same datapath, where shift ops are issued back-to-back and the consumer may stall. It uses one log-stage per shift-amount bit, giving full throughput of one operation per cycle.

Parameters:
WIDTH, 32, data width; power of two, at least 2.
SHW, $clog2(WIDTH) = 5, shift-amount width; also the pipeline depth.

Ports:
clk_i  input  1  clock; all state updates on the rising edge.
rst_i  input  1  asynchronous reset, active-high.
i_a  input  WIDTH  operand.
num_right_i  input  SHW  right-shift amount, 0..WIDTH-1.
mode_i  input  2  shift mode: 00 logical, 01 arithmetic, 10 rotate right, 11 reserved (treated as logical).
valid_i  input  1  operand, shift amount and mode are valid.
ready_o  output  1  block can accept an input this cycle.
o_y  output  WIDTH  shifted result.
valid_o  output  1  o_y is valid.
ready_i  input  1  consumer accepts o_y this cycle.

Behaviour:
- One clock and one reset: clk_i rising-edge, rst_i asynchronous active-high.
- Reset, asserted at any time including mid-operation:
  - all stage valid bits clear immediately; valid_o=0.
  - o_y=0; all stage data, amount and mode registers clear to 0.
  - ready_o=1 once reset is released (it is combinational from the cleared valids).
  - In-flight operations are discarded, not completed.
- Pipeline: stages s0..s(SHW-1). Stage k holds data, the remaining amount bits, the mode, and a valid bit.
  - At load, s0 applies bit 0 of num_right_i (shift by 1 if set) to i_a.
  - Stage k applies bit k (shift by 2^k).
  - The last stage drives o_y and valid_o directly from its registers.
- Per-step shift by n bits:
  - logical: zero-fill from the MSB.
  - arithmetic: fill with the sign bit, i_a[WIDTH-1], captured at load and carried with the data.
  - rotate: bits shifted out of the LSB re-enter at the MSB.
  - mode 11 behaves exactly as 00.
- Latency: an input accepted on edge N appears with valid_o=1 after edge N+SHW-1. That is 5 register stages; o_y is valid 5 cycles after valid_i&&ready_o is sampled, with no stalls.
- Handshake: a transfer occurs when valid&&ready are both high on a rising edge.
  - Stage enable: en_last = !valid_o || ready_i; en_k = !v_k || en_(k+1).
  - ready_o = en_0, combinational; there is no path from valid_i to ready_o.
- Bubble handling: a stage with v=0 always loads, so bubbles collapse during a stall.
- Stall: with ready_i=0 and valid_o=1, o_y and valid_o hold stable until accepted. Upstream stages keep filling bubbles; ready_o falls only when all stages are valid.
- Full: with all SHW stages valid and ready_i=0, ready_o=0.
  - When ready_i rises, ready_o=1 in the same cycle.
  - An accept and a new load occur on the same edge, with no lost or duplicated entries.
- Empty: with valid_i=0, valids drain out; valid_o drops after the last entry is accepted.
- Changes to i_a, num_right_i or mode_i while ready_o=0 and valid_i=1 have no effect until acceptance. The upstream must hold them stable.
- num_right_i=0 passes i_a unchanged in all modes, still with full latency.
- Order: strictly in-order; no reordering or combining.

Test Plan:
- Reset, then i_a=0xF0F0F0F0, num=1, mode=00, single beat -> after 5 cycles o_y=0x78787878 with valid_o=1 for exactly one cycle (ready_i=1).
- Back-to-back beats on consecutive cycles, each with i_a=0xF0F0F0F0:
  - (num=4, mode=01) -> 0xFF0F0F0F.
  - (num=4, mode=10) -> 0x0F0F0F0F.
  - (num=31, mode=00, i_a=0x80000000) -> 0x00000001.
  - Results emerge on consecutive cycles in order; ready_o stays 1 throughout.
- Rotate and reserved mode:
  - i_a=0x12345678, num=8, mode=10 -> 0x78123456.
  - Same operand, num=0, mode=11 -> 0x12345678.
  - i_a=0x80000000, num=31, mode=01 -> 0xFFFFFFFF.
- Stall:
  - Hold ready_i=0 and push 7 beats -> exactly 5 accepted; ready_o=0 after the 5th accept.
  - o_y stays stable during the stall.
  - Raising ready_i drains all 5 in order; the 6th and 7th beats are then accepted.
- Bubble collapse: a single beat, then ready_i=0 for 10 cycles -> valid_o=1 with o_y held; ready_o stays 1 throughout.
- Reset mid-operation: assert rst_i asynchronously while 3 beats are in flight -> valid_o=0 and o_y=0 immediately, before the next clock edge. After release, no stale results appear and a fresh beat completes with 5-cycle latency.
